if_pc_stage: RTL and testbench

//  PC register and IF/ID pipeline register for the miniRV pipeline. Holds the fetch PC and drives
//  the instruction ROM. Captures the fetched instruction into IF/ID. On a redirect from EX it

---
 rtl/if_pc_stage_if.sv | 29 ++
 rtl/if_pc_stage.sv | 88 ++++++++
 tb/tb_if_pc_stage.sv | 127 ++++++++++++
 3 files changed

// File: rtl/if_pc_stage_if.sv
// rtl/if_pc_stage_if.sv - fetch-stage bundle: redirect/stall controls, ROM port and IF/ID outputs
interface if_pc_stage_if;
  logic        stall_i;
  logic        redirect_i;
  logic [1:0]  npc_sel_i;
  logic [31:0] pc4_i;
  logic [31:0] pcimm_i;
  logic [31:0] immra_i;
  logic [31:0] inst_i;
  logic [31:0] irom_addr_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_pc4_o;
  logic [31:0] id_inst_o;
  logic        id_valid_o;
  logic        misalign_o;
  logic [15:0] redirect_cnt_o;

  // Pipeline/ROM side: drives controls and instruction data, observes IF/ID.
  modport master (
    output stall_i, redirect_i, npc_sel_i, pc4_i, pcimm_i, immra_i, inst_i,
    input  irom_addr_o, id_pc_o, id_pc4_o, id_inst_o, id_valid_o, misalign_o, redirect_cnt_o
  );

  // Fetch stage side.
  modport slave (
    input  stall_i, redirect_i, npc_sel_i, pc4_i, pcimm_i, immra_i, inst_i,
    output irom_addr_o, id_pc_o, id_pc4_o, id_inst_o, id_valid_o, misalign_o, redirect_cnt_o
  );
endinterface

// File: rtl/if_pc_stage.sv
// rtl/if_pc_stage.sv - miniRV PC register and IF/ID pipeline register with EX redirect and stall
module if_pc_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input logic            clk_i,
  input logic            rst_i,
  if_pc_stage_if.slave   bus
);

  logic [31:0] pc_q,       pc_d;
  logic [31:0] id_pc_q,    id_pc_d;
  logic [31:0] id_pc4_q,   id_pc4_d;
  logic [31:0] id_inst_q,  id_inst_d;
  logic        id_valid_q, id_valid_d;
  logic        misalign_q, misalign_d;
  logic [15:0] cnt_q,      cnt_d;

  logic [31:0] tgt;
  logic [31:0] pc_plus4;

  // Sequential fetch increment wraps naturally modulo 2^32.
  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    tgt = bus.pc4_i;
    case (bus.npc_sel_i)
      2'b01:   tgt = bus.pcimm_i;
      2'b10:   tgt = bus.immra_i & ~32'd1;
      default: tgt = bus.pc4_i;
    endcase
  end

  always_comb begin
    pc_d       = pc_q;
    id_pc_d    = id_pc_q;
    id_pc4_d   = id_pc4_q;
    id_inst_d  = id_inst_q;
    id_valid_d = id_valid_q;
    misalign_d = misalign_q;
    cnt_d      = cnt_q;
    if (bus.redirect_i) begin
      // Redirect beats stall: the wrong-path fetch becomes a bubble.
      pc_d       = tgt;
      id_pc_d    = 32'd0;
      id_pc4_d   = 32'd0;
      id_inst_d  = NOP_INST;
      id_valid_d = 1'b0;
      if (tgt[1:0] != 2'b00) misalign_d = 1'b1;
      if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end else if (!bus.stall_i) begin
      pc_d       = pc_plus4;
      id_pc_d    = pc_q;
      id_pc4_d   = pc_plus4;
      id_inst_d  = bus.inst_i;
      id_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q       <= RESET_PC;
      id_pc_q    <= 32'd0;
      id_pc4_q   <= 32'd0;
      id_inst_q  <= NOP_INST;
      id_valid_q <= 1'b0;
      misalign_q <= 1'b0;
      cnt_q      <= 16'd0;
    end else begin
      pc_q       <= pc_d;
      id_pc_q    <= id_pc_d;
      id_pc4_q   <= id_pc4_d;
      id_inst_q  <= id_inst_d;
      id_valid_q <= id_valid_d;
      misalign_q <= misalign_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.irom_addr_o    = pc_q;
  assign bus.id_pc_o        = id_pc_q;
  assign bus.id_pc4_o       = id_pc4_q;
  assign bus.id_inst_o      = id_inst_q;
  assign bus.id_valid_o     = id_valid_q;
  assign bus.misalign_o     = misalign_q;
  assign bus.redirect_cnt_o = cnt_q;

endmodule

// File: tb/tb_if_pc_stage.sv
// tb/tb_if_pc_stage.sv - vector table plus scoreboard queue for if_pc_stage
module tb_if_pc_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  if_pc_stage_if bus();
  // ROM[i] = i: instruction word equals its byte address.
  assign bus.inst_i = bus.irom_addr_o;

  if_pc_stage #(.RESET_PC(32'h0), .NOP_INST(32'h13)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    logic        rst, stall, redir;
    logic [1:0]  sel;
    logic [31:0] pc4, pcimm, immra;
    logic [31:0] e_pc, e_idpc, e_idpc4, e_inst;
    logic        e_v, e_m;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl[19];
  vec_t sb[$];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(logic r, logic s, logic d, logic [1:0] sel,
                              logic [31:0] p4, logic [31:0] pi, logic [31:0] ir,
                              logic [31:0] epc, logic [31:0] eid, logic [31:0] eid4,
                              logic [31:0] einst, logic ev, logic em, logic [15:0] ec);
    vec_t v;
    v.rst = r; v.stall = s; v.redir = d; v.sel = sel;
    v.pc4 = p4; v.pcimm = pi; v.immra = ir;
    v.e_pc = epc; v.e_idpc = eid; v.e_idpc4 = eid4; v.e_inst = einst;
    v.e_v = ev; v.e_m = em; v.e_cnt = ec;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    @(negedge clk);
    rst            = v.rst;
    bus.stall_i    = v.stall;
    bus.redirect_i = v.redir;
    bus.npc_sel_i  = v.sel;
    bus.pc4_i      = v.pc4;
    bus.pcimm_i    = v.pcimm;
    bus.immra_i    = v.immra;
  endtask

  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    drive(v);
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("pc",       idx, bus.irom_addr_o, e.e_pc);
    chk("id_pc",    idx, bus.id_pc_o, e.e_idpc);
    chk("id_pc4",   idx, bus.id_pc4_o, e.e_idpc4);
    chk("id_inst",  idx, bus.id_inst_o, e.e_inst);
    chk("id_valid", idx, {31'd0, bus.id_valid_o}, {31'd0, e.e_v});
    chk("misalign", idx, {31'd0, bus.misalign_o}, {31'd0, e.e_m});
    chk("cnt",      idx, {16'd0, bus.redirect_cnt_o}, {16'd0, e.e_cnt});
  endtask

  initial begin
    vec_t v;
    bus.stall_i = 1'b0; bus.redirect_i = 1'b0; bus.npc_sel_i = 2'b00;
    bus.pc4_i = '0; bus.pcimm_i = '0; bus.immra_i = '0;

    //             rst s  d  sel   pc4      pcimm    immra     pc        id_pc     id_pc4    inst      v  m  cnt
    tbl[0]  = mk(1, 0, 0, 2'd0, 32'h0,   32'h0,   32'h0,    32'h0,    32'h0,    32'h0,    32'h13,   0, 0, 16'd0);
    tbl[1]  = mk(1, 0, 0, 2'd0, 32'h0,   32'h0,   32'h0,    32'h0,    32'h0,    32'h0,    32'h13,   0, 0, 16'd0);
    tbl[2]  = mk(1, 0, 0, 2'd0, 32'h0,   32'h0,   32'h0,    32'h0,    32'h0,    32'h0,    32'h13,   0, 0, 16'd0);
    tbl[3]  = mk(0, 0, 0, 2'd0, 32'h0,   32'h0,   32'h0,    32'h4,    32'h0,    32'h4,    32'h0,    1, 0, 16'd0);
    tbl[4]  = mk(0, 0, 0, 2'd0, 32'h0,   32'h0,   32'h0,    32'h8,    32'h4,    32'h8,    32'h4,    1, 0, 16'd0);
    tbl[5]  = mk(0, 1, 0, 2'd0, 32'h0,   32'h0,   32'h0,    32'h8,    32'h4,    32'h8,    32'h4,    1, 0, 16'd0);
    tbl[6]  = mk(0, 1, 0, 2'd0, 32'h0,   32'h0,   32'h0,    32'h8,    32'h4,    32'h8,    32'h4,    1, 0, 16'd0);
    tbl[7]  = mk(0, 0, 0, 2'd0, 32'h0,   32'h0,   32'h0,    32'hC,    32'h8,    32'hC,    32'h8,    1, 0, 16'd0);
    tbl[8]  = mk(0, 0, 0, 2'd0, 32'h0,   32'h0,   32'h0,    32'h10,   32'hC,    32'h10,   32'hC,    1, 0, 16'd0);
    tbl[9]  = mk(0, 0, 1, 2'd1, 32'h14,  32'h100, 32'h55,   32'h100,  32'h0,    32'h0,    32'h13,   0, 0, 16'd1);
    tbl[10] = mk(0, 0, 0, 2'd0, 32'h0,   32'h0,   32'h0,    32'h104,  32'h100,  32'h104,  32'h100,  1, 0, 16'd1);
    tbl[11] = mk(0, 1, 1, 2'd2, 32'h108, 32'h300, 32'h203,  32'h202,  32'h0,    32'h0,    32'h13,   0, 1, 16'd2);
    tbl[12] = mk(0, 0, 0, 2'd0, 32'h0,   32'h0,   32'h0,    32'h206,  32'h202,  32'h206,  32'h202,  1, 1, 16'd2);
    tbl[13] = mk(0, 1, 0, 2'd0, 32'h0,   32'h0,   32'h0,    32'h206,  32'h202,  32'h206,  32'h202,  1, 1, 16'd2);
    tbl[14] = mk(0, 0, 1, 2'd3, 32'h40,  32'h999, 32'h777,  32'h40,   32'h0,    32'h0,    32'h13,   0, 1, 16'd3);
    tbl[15] = mk(0, 0, 1, 2'd0, 32'h80,  32'h0,   32'h0,    32'h80,   32'h0,    32'h0,    32'h13,   0, 1, 16'd4);
    tbl[16] = mk(1, 0, 1, 2'd1, 32'h0,   32'h500, 32'h0,    32'h0,    32'h0,    32'h0,    32'h13,   0, 0, 16'd0);
    tbl[17] = mk(0, 0, 0, 2'd0, 32'h0,   32'h0,   32'h0,    32'h4,    32'h0,    32'h4,    32'h0,    1, 0, 16'd0);
    tbl[18] = mk(1, 1, 0, 2'd0, 32'h0,   32'h0,   32'h0,    32'h0,    32'h0,    32'h0,    32'h13,   0, 0, 16'd0);

    for (int i = 0; i < 19; i++) apply(tbl[i], i);

    // Counter saturation: 65534 unchecked redirects, then checked ones at and past the limit.
    v = mk(0, 0, 1, 2'd0, 32'h1000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 16'd0);
    for (int i = 0; i < 65534; i++) begin
      drive(v);
      @(posedge clk);
    end
    apply(mk(0, 0, 1, 2'd0, 32'h1000, 32'h0, 32'h0,
             32'h1000, 32'h0, 32'h0, 32'h13, 0, 0, 16'hFFFF), 100);
    apply(mk(0, 0, 1, 2'd1, 32'h0, 32'hFFFF_FFFC, 32'h0,
             32'hFFFF_FFFC, 32'h0, 32'h0, 32'h13, 0, 0, 16'hFFFF), 101);
    // Sequential pc+4 wraps to zero.
    apply(mk(0, 0, 0, 2'd0, 32'h0, 32'h0, 32'h0,
             32'h0, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFFC, 1, 0, 16'hFFFF), 102);
    // Reset coincident with redirect clears the saturated counter.
    apply(mk(1, 0, 1, 2'd2, 32'h0, 32'h0, 32'h303,
             32'h0, 32'h0, 32'h0, 32'h13, 0, 0, 16'd0), 103);

    chk("sb_empty", 0, sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
